corrimiento: RTL and testbench



---
 rtl/corrimiento_pkg.sv | 11 +
 rtl/corrimiento_sat_counter.sv | 44 ++++
 rtl/corrimiento.sv | 78 +++++++
 tb/tb_corrimiento.sv | 129 ++++++++++++
 4 files changed

// File: rtl/corrimiento_pkg.sv
// Shared control encoding and types for the echo shift register.
package corrimiento_pkg;

  typedef logic [1:0] ctrl_t;

  localparam ctrl_t CTRL_HOLD = 2'b00;
  localparam ctrl_t CTRL_SHR  = 2'b01;
  localparam ctrl_t CTRL_SHL  = 2'b10;
  localparam ctrl_t CTRL_LOAD = 2'b11;

endpackage : corrimiento_pkg

// File: rtl/corrimiento_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered "at max" flag.
module corrimiento_sat_counter #(
  parameter int unsigned MAX   = 8,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next count: clear wins, otherwise count up and stick at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    sat_d = (cnt_d == CntMax);
  end

  // Counter and flag registers; reset is synchronous, active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule : corrimiento_sat_counter

// File: rtl/corrimiento.sv
// Loadable shift register: captures an echo sample, shifts it out serially
// in either direction, and counts shifts until the word is exhausted.
module corrimiento
  import corrimiento_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] echo,
  input  ctrl_t            ctrl,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             shift_en;
  logic             load_en;

  assign shift_en = (ctrl == CTRL_SHR) || (ctrl == CTRL_SHL);
  assign load_en  = (ctrl == CTRL_LOAD);

  // Data path next state: zero-fill shifts, no rotate; the exiting bit goes to ser_out.
  always_comb begin
    q_d   = q_q;
    ser_d = ser_q;
    unique case (ctrl)
      CTRL_SHR: begin
        q_d   = {1'b0, q_q[WIDTH-1:1]};
        ser_d = q_q[0];
      end
      CTRL_SHL: begin
        q_d   = {q_q[WIDTH-2:0], 1'b0};
        ser_d = q_q[WIDTH-1];
      end
      CTRL_LOAD: begin
        q_d   = echo;
        ser_d = 1'b0;
      end
      default: begin
        q_d   = q_q;
        ser_d = ser_q;
      end
    endcase
  end

  // Shift register and serial output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q   <= '0;
      ser_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ser_q <= ser_d;
    end
  end

  // Shift counter: cleared on load, saturates once the whole word is out.
  corrimiento_sat_counter #(
    .MAX   (WIDTH),
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (load_en),
    .en_i  (shift_en),
    .cnt_o (shift_cnt),
    .sat_o (done)
  );

  assign q       = q_q;
  assign ser_out = ser_q;

endmodule : corrimiento

// File: tb/tb_corrimiento.sv
// Directed bench for the echo shift register.
module tb_corrimiento;
  import corrimiento_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] echo;
  ctrl_t      ctrl;
  logic [7:0] q;
  logic       ser_out;
  logic [3:0] shift_cnt;
  logic       done;

  int unsigned vectors;
  int unsigned errors;

  corrimiento #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .echo      (echo),
    .ctrl      (ctrl),
    .q         (q),
    .ser_out   (ser_out),
    .shift_cnt (shift_cnt),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across a rising edge, settle before checking.
  task automatic step(input logic r, input ctrl_t c, input logic [7:0] e);
    reset = r;
    ctrl  = c;
    echo  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                         input logic [3:0] ec, input logic ed);
    chk({tag, ".q"},    32'(q),         32'(eq));
    chk({tag, ".ser"},  32'(ser_out),   32'(es));
    chk({tag, ".cnt"},  32'(shift_cnt), 32'(ec));
    chk({tag, ".done"}, 32'(done),      32'(ed));
  endtask

  // Hand-computed SHR sequence from 8'hAE: q after each shift and bit shifted out.
  logic [7:0] shr_q   [8] = '{8'h57, 8'h2B, 8'h15, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
  logic       shr_ser [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    vectors = 0;
    errors  = 0;
    reset   = 1'b0;
    ctrl    = CTRL_HOLD;
    echo    = 8'hAE;

    // Reset for two edges; echo present must not leak in.
    step(1'b0, CTRL_LOAD, 8'hAE);
    step(1'b0, CTRL_LOAD, 8'hAE);
    chk_all("reset", 8'h00, 1'b0, 4'd0, 1'b0);

    // Load and two right shifts.
    step(1'b1, CTRL_LOAD, 8'hAE);
    chk_all("load", 8'hAE, 1'b0, 4'd0, 1'b0);
    step(1'b1, CTRL_SHR, 8'h00);
    chk_all("shr1", 8'h57, 1'b0, 4'd1, 1'b0);
    step(1'b1, CTRL_SHR, 8'h00);
    chk_all("shr2", 8'h2B, 1'b1, 4'd2, 1'b0);

    // Left shift then hold.
    step(1'b1, CTRL_LOAD, 8'hAE);
    step(1'b1, CTRL_SHL, 8'h00);
    chk_all("shl1", 8'h5C, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CTRL_HOLD, 8'hFF);
      chk_all("hold", 8'h5C, 1'b1, 4'd1, 1'b0);
    end

    // Full word out, done on the eighth shift, then saturation.
    step(1'b1, CTRL_LOAD, 8'hAE);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, CTRL_SHR, 8'h00);
      chk_all("shr8", shr_q[i], shr_ser[i], 4'(i + 1), (i == 7));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, CTRL_SHR, 8'h00);
      chk_all("sat", 8'h00, 1'b0, 4'd8, 1'b1);
    end
    step(1'b1, CTRL_SHL, 8'h00);
    chk_all("sat_shl", 8'h00, 1'b0, 4'd8, 1'b1);

    // Load clears done; mixed directions lose bits rather than rotating.
    step(1'b1, CTRL_LOAD, 8'hAE);
    chk_all("reload", 8'hAE, 1'b0, 4'd0, 1'b0);
    step(1'b1, CTRL_SHR, 8'h00);
    step(1'b1, CTRL_SHL, 8'h00);
    chk_all("mix_rl", 8'hAE, 1'b0, 4'd2, 1'b0);
    step(1'b1, CTRL_SHL, 8'h00);
    chk_all("mix_l", 8'h5C, 1'b1, 4'd3, 1'b0);
    step(1'b1, CTRL_SHR, 8'h00);
    chk_all("mix_r", 8'h2E, 1'b0, 4'd4, 1'b0);

    // Reset mid-shift overrides LOAD, then a fresh load.
    step(1'b1, CTRL_LOAD, 8'hAE);
    for (int i = 0; i < 3; i++) step(1'b1, CTRL_SHR, 8'h00);
    chk_all("pre_rst", 8'h15, 1'b1, 4'd3, 1'b0);
    step(1'b0, CTRL_LOAD, 8'hAE);
    chk_all("mid_rst", 8'h00, 1'b0, 4'd0, 1'b0);
    step(1'b1, CTRL_LOAD, 8'hFF);
    chk_all("load_ff", 8'hFF, 1'b0, 4'd0, 1'b0);
    step(1'b1, CTRL_SHL, 8'h00);
    chk_all("shl_ff", 8'hFE, 1'b1, 4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_corrimiento
